// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - load/store unit converting byte/half/word accesses into word memory accesses
//
// Optional feature macro: LSU_ALIGN_CHECK_EN (alignment errors for lh/lhu/sh and lw/sw)
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i, we_i, size_i   core request, store select, RV32I funct3 size code
//   addr_i, wd_i          core byte address, right-aligned store data
//   ready_o, done_o       idle indication, one-cycle completion pulse
//   err_o, rd_o           error pulse (with done_o), registered load result
//   mem_a_o, mem_we_o     word-aligned memory address, memory write enable
//   mem_wd_o, mem_rd_i    memory write data, combinational memory read data
`timescale 1ns/1ps

module lsu_mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wd_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rd_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic [31:0]       r_rd;
  logic              r_err;

  logic [ADDR_W-1:0] w_addr_al;
  logic              w_accept;
  logic              w_size_ok;
  logic              w_misalign;
  logic              w_error;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_addr_al = {addr_i[ADDR_W-1:2], 2'b00};
  assign w_accept  = req_i & (r_state == S_IDLE);

  // Stores only know sb/sh/sw; loads additionally have the unsigned variants.
  always_comb begin
    w_size_ok = 1'b0;
    if (we_i) begin
      w_size_ok = (size_i == 3'd0) || (size_i == 3'd1) || (size_i == 3'd2);
    end else begin
      w_size_ok = (size_i == 3'd0) || (size_i == 3'd1) || (size_i == 3'd2) ||
                  (size_i == 3'd4) || (size_i == 3'd5);
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  // size_i[1:0] is 1 for lh/lhu/sh and 2 for lw/sw among the legal codes.
  assign w_misalign = ((size_i[1:0] == 2'd1) && addr_i[0]) ||
                      ((size_i[1:0] == 2'd2) && (addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_error = ~w_size_ok | w_misalign;

  // Lane extraction: byte lane from addr[1:0], half lane from addr[1] only.
  always_comb begin
    w_byte = mem_rd_i[7:0];
    case (addr_i[1:0])
      2'd0:    w_byte = mem_rd_i[7:0];
      2'd1:    w_byte = mem_rd_i[15:8];
      2'd2:    w_byte = mem_rd_i[23:16];
      default: w_byte = mem_rd_i[31:24];
    endcase
  end

  assign w_half = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    w_load = mem_rd_i;
    case (size_i)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = mem_rd_i;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane of the current word.
  always_comb begin
    w_merge = mem_rd_i;
    case (size_i[1:0])
      2'd0: begin
        case (addr_i[1:0])
          2'd0:    w_merge[7:0]   = wd_i[7:0];
          2'd1:    w_merge[15:8]  = wd_i[7:0];
          2'd2:    w_merge[23:16] = wd_i[7:0];
          default: w_merge[31:24] = wd_i[7:0];
        endcase
      end
      2'd1: begin
        if (addr_i[1]) begin
          w_merge[31:16] = wd_i[15:0];
        end else begin
          w_merge[15:0] = wd_i[15:0];
        end
      end
      default: w_merge = wd_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wd    <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= w_addr_al;
            if (w_error) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else if (we_i) begin
              r_wd    <= w_merge;
              r_err   <= 1'b0;
              r_state <= S_WRITE;
            end else begin
              r_rd    <= w_load;
              r_err   <= 1'b0;
              r_state <= S_RESP;
            end
          end
        end
        S_WRITE: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // All handshake and memory-control outputs decode the state register, so an
  // asynchronous reset removes them immediately.
  assign ready_o  = (r_state == S_IDLE);
  assign done_o   = (r_state == S_RESP);
  assign err_o    = (r_state == S_RESP) & r_err;
  assign mem_we_o = (r_state == S_WRITE);
  assign mem_wd_o = r_wd;
  assign rd_o     = r_rd;
  assign mem_a_o  = (r_state == S_IDLE) ? w_addr_al : r_addr;

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - scoreboard testbench for lsu_mem_access
`timescale 1ns/1ps

module tb_lsu_mem_access;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  size_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wd_i = 32'd0;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rd_o;
  logic [31:0] mem_a_o;
  logic        mem_we_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  logic [31:0] mem [0:63];
  logic [32:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  lsu_mem_access #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .addr_i(addr_i), .wd_i(wd_i), .ready_o(ready_o), .done_o(done_o),
    .err_o(err_o), .rd_o(rd_o), .mem_a_o(mem_a_o), .mem_we_o(mem_we_o),
    .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_rd_i = mem[mem_a_o[7:2]];

  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_a_o[7:2]] <= mem_wd_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk_i) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_o=1 expected no response");
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk1("resp_err", err_o, e[32]);
        chk("resp_rd", rd_o, e[31:0]);
      end
    end
  end

  // Issue one request; returns at the negedge of cycle T+1.
  task automatic do_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
    exp_q.push_back({exp_err, exp_rd});
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wd_i = wd;
    #1;
    chk("mem_a_idle", mem_a_o, {a[31:2], 2'b00});
    @(negedge clk_i);
    req_i = 1'b0;
    chk1("ready_t1", ready_o, 1'b0);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got ready_o=0 expected ready_o=1 within 6 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r9, r10;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4]  = 32'h8899AABB;
    mem[63] = 32'h0BADF00D;

    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk1("rst_ready", ready_o, 1'b1);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk("rst_rd", rd_o, 32'h0);
    chk1("rst_we", mem_we_o, 1'b0);
    chk("rst_wd", mem_wd_o, 32'h0);

    // Loads with sign/zero extension.
    do_op(1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAA);
    chk1("lb_no_we", mem_we_o, 1'b0);
    wait_idle();
    do_op(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h00000088); wait_idle();
    do_op(1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h00008899); wait_idle();
    do_op(1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'hFFFFAABB); wait_idle();

    // Byte store read-modify-write.
    do_op(1'b1, 3'd0, 32'h12, 32'h123456CC, 1'b0, 32'hFFFFAABB);
    chk1("sb_we", mem_we_o, 1'b1);
    chk("sb_addr", mem_a_o, 32'h10);
    chk("sb_wd", mem_wd_o, 32'h88CCAABB);
    wait_idle();
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h88CCAABB); wait_idle();

    // Word store with an ignored request while busy.
    do_op(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 1'b0, 32'h88CCAABB);
    req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h10;
    @(negedge clk_i);
    req_i = 1'b0;
    chk1("sw_ready_t2", ready_o, 1'b0);
    wait_idle();
    do_op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'hDEADBEEF); wait_idle();

    // Misaligned half and word loads.
    r9 = ALIGN ? 32'hDEADBEEF : 32'hFFFFAABB;
    do_op(1'b0, 3'd1, 32'h11, 32'h0, ALIGN, r9); wait_idle();
    r10 = ALIGN ? r9 : 32'h88CCAABB;
    do_op(1'b0, 3'd2, 32'h13, 32'h0, ALIGN, r10); wait_idle();

    // Illegal sizes.
    do_op(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b1, r10);
    chk1("bad_store_no_we", mem_we_o, 1'b0);
    wait_idle();
    chk("bad_store_mem", mem[4], 32'h88CCAABB);
    do_op(1'b0, 3'd6, 32'h10, 32'h0, 1'b1, r10); wait_idle();
    do_op(1'b0, 3'd3, 32'h10, 32'h0, 1'b1, r10); wait_idle();

    // Half and byte stores into the upper lanes.
    do_op(1'b1, 3'd1, 32'h22, 32'h0000CAFE, 1'b0, r10);
    chk("sh_wd", mem_wd_o, 32'hCAFEBEEF);
    wait_idle();
    do_op(1'b1, 3'd0, 32'h21, 32'h00000055, 1'b0, r10);
    chk("sb21_wd", mem_wd_o, 32'hCAFE55EF);
    wait_idle();
    do_op(1'b0, 3'd4, 32'h21, 32'h0, 1'b0, 32'h00000055); wait_idle();
    do_op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'hCAFE55EF); wait_idle();

    // Top-of-address-space word.
    do_op(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h0BADF00D); wait_idle();

    // Restore word 0x10, then reset in the middle of a half store.
    do_op(1'b1, 3'd2, 32'h10, 32'h8899AABB, 1'b0, 32'h0BADF00D); wait_idle();
    do_op(1'b1, 3'd1, 32'h10, 32'h00001111, 1'b0, 32'h0);
    chk1("rst_mid_we_before", mem_we_o, 1'b1);
    void'(exp_q.pop_back());
    #2;
    rst_i = 1'b1;
    #1;
    chk1("rst_mid_we_drop", mem_we_o, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_mem", mem[4], 32'h8899AABB);
    chk1("rst_mid_ready", ready_o, 1'b1);
    chk("rst_mid_rd", rd_o, 32'h0);
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h8899AABB); wait_idle();

    repeat (3) @(negedge clk_i);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
